vram_arbiter: RTL

// Shares the single-port 2K x 16 video RAM (char byte low, colour/attribute byte high)

---
 rtl/vram_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port 2K x 16 VRAM between fixed-latency video fetches, CPU byte access and an optional
// clear engine (enabled by defining VRAM_CLEAR_EN). Priority is video > CPU > clear, with one issue slot per clock.
module vram_arbiter #(
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic [15:0]       vid_data_o,
    output logic              vid_valid_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic              cpu_bsel_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_din_i,
    output logic [7:0]        cpu_dout_o,
    output logic              cpu_ack_o,
    output logic              ram_en_o,
    output logic [1:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [15:0]       ram_din_o,
    input  logic [15:0]       ram_dout_i,
    input  logic              clr_start_i,
    input  logic [15:0]       clr_value_i,
    output logic              clr_busy_o
);
    typedef enum logic [1:0] {C_IDLE, C_BUSY, C_ACK} cpu_state_e;
    typedef enum logic [1:0] {O_NONE, O_VID, O_CPU} owner_e;

    cpu_state_e        cpu_state_q;
    owner_e            own1_q, own2_q, own_d;
    logic              cpu_wr_q, cpu_bsel_q, cpu_ack_q, vid_valid_q;
    logic [7:0]        cpu_dout_q;
    logic [15:0]       vid_data_q;
    logic              ram_en_q, ram_en_d;
    logic [1:0]        ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]       ram_din_q, ram_din_d;
    logic              cpu_go, clr_go, clr_busy;
    logic [ADDR_W-1:0] clr_cnt;
    logic [15:0]       clr_word;

`ifdef VRAM_CLEAR_EN
    logic              clr_busy_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    assign clr_busy = clr_busy_q;
    assign clr_cnt  = clr_cnt_q;
    assign clr_word = clr_value_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
        end else if (!clr_busy_q) begin
            if (clr_start_i) begin
                clr_busy_q <= 1'b1;
                clr_cnt_q  <= '0;
            end
        end else if (clr_go) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (&clr_cnt_q) clr_busy_q <= 1'b0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = ^{clr_start_i, clr_value_i};
    assign clr_busy   = 1'b0;
    assign clr_cnt    = '0;
    assign clr_word   = 16'h0000;
`endif

    // Only CPU reads need their data routed back; writes complete without an owner.
    always_comb begin
        cpu_go     = cpu_state_q == C_IDLE && cpu_req_i && !vid_req_i;
        clr_go     = clr_busy && !vid_req_i && !cpu_go;
        ram_en_d   = vid_req_i || cpu_go || clr_go;
        ram_we_d   = vid_req_i ? 2'b00 :
                     cpu_go    ? (cpu_we_i ? (cpu_bsel_i ? 2'b10 : 2'b01) : 2'b00) :
                     clr_go    ? 2'b11 : 2'b00;
        ram_addr_d = vid_req_i ? vid_addr_i : cpu_go ? cpu_addr_i : clr_cnt;
        ram_din_d  = cpu_go ? {cpu_din_i, cpu_din_i} : clr_word;
        own_d      = vid_req_i ? O_VID : (cpu_go && !cpu_we_i) ? O_CPU : O_NONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_state_q <= C_IDLE;
            own1_q      <= O_NONE;
            own2_q      <= O_NONE;
            cpu_wr_q    <= 1'b0;
            cpu_bsel_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_dout_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            own1_q      <= own_d;
            own2_q      <= own1_q;
            vid_valid_q <= own2_q == O_VID;
            if (own2_q == O_VID) vid_data_q <= ram_dout_i;
            cpu_ack_q   <= 1'b0;
            if (cpu_state_q == C_IDLE) begin
                if (cpu_go) begin
                    cpu_state_q <= C_BUSY;
                    cpu_wr_q    <= cpu_we_i;
                    cpu_bsel_q  <= cpu_bsel_i;
                end
            end else if (cpu_state_q == C_BUSY) begin
                if (cpu_wr_q || own2_q == O_CPU) begin
                    cpu_state_q <= C_ACK;
                    cpu_ack_q   <= 1'b1;
                    if (!cpu_wr_q) cpu_dout_q <= cpu_bsel_q ? ram_dout_i[15:8] : ram_dout_i[7:0];
                end
            end else begin
                cpu_state_q <= C_IDLE;
            end
        end
    end

    assign vid_data_o  = vid_data_q;
    assign vid_valid_o = vid_valid_q;
    assign cpu_dout_o  = cpu_dout_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_din_o   = ram_din_q;
    assign clr_busy_o  = clr_busy;
endmodule
